alu_secuencial: RTL and testbench
=================================

ALU_SECUENCIAL -- requirements
Module: alu_secuencial

Interface
REQ-001 SHALL have parameters: NBITS, 32, operand/result width; ALUOP, 4, ALU control code MSB index (code is ALUOP+1 = 5 bits); NBITSSH, 5, shift-amount width.
REQ-002 SHALL have ports (one clock; reset asynchronous, active-low):
 i_clk  input  1  rising-edge clock
 i_reset_n  input  1  asynchronous active-low reset
 i_start  input  1  operation request, sampled only in IDLE
 i_ALUCtrl  input  ALUOP+1  operation code from ALU control decoder
 i_A  input  NBITS  operand A (rs)
 i_B  input  NBITS  operand B (rt/immediate)
 i_shamt  input  NBITSSH  shift amount
 o_busy  output  1  multi-cycle operation in progress
 o_valid  output  1  one-cycle pulse: o_result/HI/LO updated
 o_result  output  NBITS  registered result
 o_zero  output  1  registered (o_result == 0)
 o_divzero  output  1  one-cycle pulse with o_valid on division by zero

Function
REQ-003 SHALL implement codes: 00 AND, 01 OR, 02 ADD, 03 XOR, 04 NOR, 05 SUB, 06 SLT signed, 07 SLTU, 08 SLL, 09 SRL, 0A SRA, 0B LUI (B<<16), 10 MULTU, 11 MULT, 12 DIVU, 13 DIV, 14 MFHI, 15 MFLO; hex values.
REQ-004 SHALL treat undefined codes as single-cycle ops yielding o_result=0, HI/LO unchanged.
REQ-005 SHALL use FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-006 IDLE + i_start + single-cycle code at edge N: SHALL register o_result at edge N, go DONE; o_valid high for the cycle after edge N; DONE -> IDLE next edge.
REQ-007 ADD/SUB SHALL wrap modulo 2^NBITS; no overflow trap; SLT/SLTU SHALL produce 0 or 1.
REQ-008 Shifts SHALL use i_shamt (not i_B); SRA sign-extends.
REQ-009 IDLE + i_start + MULT/MULTU at edge N: SHALL latch operands (magnitudes for MULT), enter MUL, iterate shift-add one bit per edge for 32 edges (N+1..N+32).
REQ-010 At edge N+32 SHALL write 64-bit product to {HI,LO} (two's-complement negated if MULT signs differ), o_result=LO, go DONE; o_valid high for one cycle after N+32.
REQ-011 DIV/DIVU SHALL use restoring division, same 32-iteration timing; LO=quotient, HI=remainder; DIV truncates toward zero, remainder takes dividend sign.
REQ-012 Divisor 0: SHALL still take 32 iterations, then LO=FFFFFFFF, HI=i_A latched, o_divzero pulse with o_valid.
REQ-013 DIV 80000000 / FFFFFFFF SHALL give LO=80000000, HI=00000000, no o_divzero.
REQ-014 MFHI/MFLO SHALL be single-cycle, o_result=HI or LO.
REQ-015 o_busy SHALL be high exactly while state is MUL or DIV.
REQ-016 i_start while not IDLE SHALL be ignored with no effect on state, operands, HI, LO.
REQ-017 i_start held high continuously SHALL start a new operation on each edge where state is IDLE.
REQ-018 Operand inputs SHALL be don't-care after the start edge; changes SHALL not affect in-flight result.
REQ-019 o_zero SHALL update on the same edge as o_result.
REQ-020 o_result, o_zero SHALL hold value between operations.

Reset
REQ-021 i_reset_n low SHALL immediately force IDLE, o_busy=0, o_valid=0, o_divzero=0, o_result=0, o_zero=1, HI=0, LO=0, iteration counter=0.
REQ-022 Reset mid MUL/DIV SHALL abort; no o_valid pulse; HI/LO cleared.
REQ-023 Release SHALL be synchronised by the clock; first start accepted on first rising edge with i_reset_n high.

Verification
REQ-024 ADD A=FFFFFFFF B=00000001 -> o_valid 1 cycle after start, o_result=0, o_zero=1.
REQ-025 MULT A=FFFFFFFE(-2) B=00000003 -> o_busy 32 cycles, o_valid after edge N+32, HI=FFFFFFFF, LO=FFFFFFFA; MFHI then returns FFFFFFFF.
REQ-026 DIV A=FFFFFFF9(-7) B=00000002 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU A=7 B=0 -> LO=FFFFFFFF, HI=7, o_divzero pulse.
REQ-027 i_start with ADD pulsed during MULTU busy -> ignored; only MULTU o_valid observed; HI/LO match MULTU.
REQ-028 Assert i_reset_n low at iteration 10 of DIVU -> no o_valid, HI=LO=0, o_busy=0; next SLT A=80000000 B=1 -> o_result=1.
REQ-029 SRA A=x B=80000000 shamt=4 -> o_result=F8000000; undefined code 1F -> o_result=0, o_zero=1.

Source files
------------

// File: rtl/alu_secuencial.sv
// Sequential MIPS-style ALU: single-cycle logic/arith/shift ops, plus
// 32-iteration shift-add multiply and restoring divide writing a HI/LO pair.
module alu_secuencial #(
    parameter int NBITS   = 32,
    parameter int ALUOP   = 4,
    parameter int NBITSSH = 5
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [ALUOP:0]     i_ALUCtrl,
    input  logic [NBITS-1:0]   i_A,
    input  logic [NBITS-1:0]   i_B,
    input  logic [NBITSSH-1:0] i_shamt,
    output logic               o_busy,
    output logic               o_valid,
    output logic [NBITS-1:0]   o_result,
    output logic               o_zero,
    output logic               o_divzero
);

    localparam int CNTW = $clog2(NBITS);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NBITS - 1);

    localparam logic [ALUOP:0] OP_AND   = (ALUOP+1)'('h00);
    localparam logic [ALUOP:0] OP_OR    = (ALUOP+1)'('h01);
    localparam logic [ALUOP:0] OP_ADD   = (ALUOP+1)'('h02);
    localparam logic [ALUOP:0] OP_XOR   = (ALUOP+1)'('h03);
    localparam logic [ALUOP:0] OP_NOR   = (ALUOP+1)'('h04);
    localparam logic [ALUOP:0] OP_SUB   = (ALUOP+1)'('h05);
    localparam logic [ALUOP:0] OP_SLT   = (ALUOP+1)'('h06);
    localparam logic [ALUOP:0] OP_SLTU  = (ALUOP+1)'('h07);
    localparam logic [ALUOP:0] OP_SLL   = (ALUOP+1)'('h08);
    localparam logic [ALUOP:0] OP_SRL   = (ALUOP+1)'('h09);
    localparam logic [ALUOP:0] OP_SRA   = (ALUOP+1)'('h0A);
    localparam logic [ALUOP:0] OP_LUI   = (ALUOP+1)'('h0B);
    localparam logic [ALUOP:0] OP_MULTU = (ALUOP+1)'('h10);
    localparam logic [ALUOP:0] OP_MULT  = (ALUOP+1)'('h11);
    localparam logic [ALUOP:0] OP_DIVU  = (ALUOP+1)'('h12);
    localparam logic [ALUOP:0] OP_DIV   = (ALUOP+1)'('h13);
    localparam logic [ALUOP:0] OP_MFHI  = (ALUOP+1)'('h14);
    localparam logic [ALUOP:0] OP_MFLO  = (ALUOP+1)'('h15);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    // acc holds {partial product, multiplier} for MUL and
    // {partial remainder, dividend/quotient} for DIV.
    logic [2*NBITS-1:0]   acc_q, acc_d;
    logic [NBITS-1:0]     opb_q, opb_d;      // multiplicand or divisor magnitude
    logic                 neg_q, neg_d;      // negate product / quotient at the end
    logic                 aneg_q, aneg_d;    // dividend was negative (remainder sign)
    logic                 dz_q, dz_d;        // divisor was zero
    logic [NBITS-1:0]     hi_q, hi_d;
    logic [NBITS-1:0]     lo_q, lo_d;
    logic [NBITS-1:0]     res_q, res_d;
    logic                 zero_q, zero_d;
    logic                 valid_q, valid_d;
    logic                 divz_q, divz_d;

    logic [NBITS-1:0]     alu_res;
    logic                 op_is_signed;
    logic [NBITS-1:0]     a_mag, b_mag;
    logic [NBITS:0]       mul_sum;
    logic [2*NBITS-1:0]   mul_next, prod;
    logic [NBITS:0]       div_shift;
    logic [NBITS-1:0]     div_diff, div_rem, quot, rem_f;
    logic                 div_ge;
    logic [2*NBITS-1:0]   div_next;

    // Single-cycle datapath; shifts act on i_B by i_shamt, MIPS style.
    always_comb begin
        // NOTE: assign a default before the case so every path drives alu_res
        // and no latch is inferred.
        alu_res = '0;
        case (i_ALUCtrl)
            OP_AND:  alu_res = i_A & i_B;
            OP_OR:   alu_res = i_A | i_B;
            OP_ADD:  alu_res = i_A + i_B;
            OP_XOR:  alu_res = i_A ^ i_B;
            OP_NOR:  alu_res = ~(i_A | i_B);
            OP_SUB:  alu_res = i_A - i_B;
            OP_SLT:  alu_res = {{(NBITS-1){1'b0}}, ($signed(i_A) < $signed(i_B))};
            OP_SLTU: alu_res = {{(NBITS-1){1'b0}}, (i_A < i_B)};
            OP_SLL:  alu_res = i_B << i_shamt;
            OP_SRL:  alu_res = i_B >> i_shamt;
            OP_SRA:  alu_res = NBITS'($signed(i_B) >>> i_shamt);
            OP_LUI:  alu_res = i_B << 16;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // Operand magnitudes and one iteration of shift-add / restoring divide.
    always_comb begin
        op_is_signed = i_ALUCtrl[0];   // MULT and DIV are the odd codes
        a_mag = (op_is_signed && i_A[NBITS-1]) ? -i_A : i_A;
        b_mag = (op_is_signed && i_B[NBITS-1]) ? -i_B : i_B;

        mul_sum  = {1'b0, acc_q[2*NBITS-1:NBITS]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[NBITS-1:1]};
        prod     = neg_q ? -mul_next : mul_next;

        // With a zero divisor every step subtracts nothing, so the quotient
        // fills with ones and the remainder ends up as the dividend magnitude.
        div_shift = {acc_q[2*NBITS-1:NBITS], acc_q[NBITS-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_diff  = div_shift[NBITS-1:0] - opb_q;
        div_rem   = div_ge ? div_diff : div_shift[NBITS-1:0];
        div_next  = {div_rem, acc_q[NBITS-2:0], div_ge};
        quot      = div_next[NBITS-1:0];
        rem_f     = aneg_q ? -div_next[2*NBITS-1:NBITS] : div_next[2*NBITS-1:NBITS];
    end

    // Next-state and register-update logic for the IDLE/MUL/DIV/DONE sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        aneg_d  = aneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        zero_d  = zero_q;
        valid_d = 1'b0;
        divz_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    cnt_d = '0;
                    if (i_ALUCtrl == OP_MULT || i_ALUCtrl == OP_MULTU) begin
                        state_d = MUL;
                        acc_d   = {{NBITS{1'b0}}, a_mag};
                        opb_d   = b_mag;
                        neg_d   = op_is_signed && (i_A[NBITS-1] ^ i_B[NBITS-1]);
                    end else if (i_ALUCtrl == OP_DIV || i_ALUCtrl == OP_DIVU) begin
                        state_d = DIV;
                        acc_d   = {{NBITS{1'b0}}, a_mag};
                        opb_d   = b_mag;
                        neg_d   = op_is_signed && (i_A[NBITS-1] ^ i_B[NBITS-1]);
                        aneg_d  = op_is_signed && i_A[NBITS-1];
                        dz_d    = (i_B == '0);
                    end else begin
                        state_d = DONE;
                        res_d   = alu_res;
                        zero_d  = (alu_res == '0);
                        valid_d = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    hi_d    = prod[2*NBITS-1:NBITS];
                    lo_d    = prod[NBITS-1:0];
                    res_d   = prod[NBITS-1:0];
                    zero_d  = (prod[NBITS-1:0] == '0);
                    valid_d = 1'b1;
                end
            end
            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    hi_d    = rem_f;
                    lo_d    = dz_q ? '1 : (neg_q ? -quot : quot);
                    res_d   = dz_q ? '1 : (neg_q ? -quot : quot);
                    zero_d  = !dz_q && (quot == '0);
                    valid_d = 1'b1;
                    divz_d  = dz_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight operation and clears HI/LO.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            aneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            aneg_q  <= aneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
            divz_q  <= divz_d;
        end
    end

    assign o_busy    = (state_q == MUL) || (state_q == DIV);
    assign o_valid   = valid_q;
    assign o_result  = res_q;
    assign o_zero    = zero_q;
    assign o_divzero = divz_q;

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed self-checking bench for alu_secuencial: vector table plus
// hand-written sequences for busy-ignore, held start and mid-operation reset.
module tb_alu_secuencial;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_start;
    logic [4:0]  i_ALUCtrl;
    logic [31:0] i_A;
    logic [31:0] i_B;
    logic [4:0]  i_shamt;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_zero;
    logic        o_divzero;

    int n_tests = 0;
    int n_fail  = 0;

    alu_secuencial #(.NBITS(32), .ALUOP(4), .NBITSSH(5)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_start   (i_start),
        .i_ALUCtrl (i_ALUCtrl),
        .i_A       (i_A),
        .i_B       (i_B),
        .i_shamt   (i_shamt),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_result  (o_result),
        .o_zero    (o_zero),
        .o_divzero (o_divzero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        logic [4:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp_res;
        int          exp_lat;
        logic        exp_dz;
        bit          has_hilo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic [4:0] code,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, input logic [31:0] exp_res,
                                input int exp_lat, input logic exp_dz,
                                input bit has_hilo, input logic [31:0] exp_hi,
                                input logic [31:0] exp_lo);
        vec_t v;
        v.name = name; v.code = code; v.a = a; v.b = b; v.sh = sh;
        v.exp_res = exp_res; v.exp_lat = exp_lat; v.exp_dz = exp_dz;
        v.has_hilo = has_hilo; v.exp_hi = exp_hi; v.exp_lo = exp_lo;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation, scramble operands after the start edge, and wait
    // (bounded) for o_valid. lat counts edges after the start edge.
    task automatic run_op(input logic [4:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          output logic [31:0] res, output logic z, output logic dz,
                          output int lat, output int busy_n,
                          output logic v_after, output logic [31:0] res_hold);
        @(negedge i_clk);
        i_ALUCtrl = code; i_A = a; i_B = b; i_shamt = sh; i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_A = $urandom; i_B = $urandom; i_shamt = 5'($urandom); i_ALUCtrl = 5'($urandom);
        lat = 0;
        busy_n = 0;
        while (!o_valid && lat < 100) begin
            if (o_busy) busy_n++;
            @(posedge i_clk);
            #1;
            lat++;
        end
        res = o_result;
        z   = o_zero;
        dz  = o_divzero;
        @(posedge i_clk);
        #1;
        v_after  = o_valid;
        res_hold = o_result;
    endtask

    task automatic read_reg(input logic [4:0] code, output logic [31:0] val);
        logic z, dz, va;
        logic [31:0] rh;
        int lat, bn;
        run_op(code, 32'h0, 32'h0, 5'd0, val, z, dz, lat, bn, va, rh);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res, rh, hi, lo;
        logic        z, dz, va;
        int          lat, bn, vcnt, vlat, bcnt;

        i_reset_n = 1'b0;
        i_start   = 1'b0;
        i_ALUCtrl = 5'h00;
        i_A       = '0;
        i_B       = '0;
        i_shamt   = '0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_busy",    o_busy,    0);
        check("rst_valid",   o_valid,   0);
        check("rst_divzero", o_divzero, 0);
        check("rst_result",  o_result,  0);
        check("rst_zero",    o_zero,    1);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        read_reg(5'h14, hi);
        check("rst_hi", hi, 0);
        read_reg(5'h15, lo);
        check("rst_lo", lo, 0);

        // ---------------- vector table ----------------
        vecs.push_back(mk("add_wrap", 5'h02, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("and",      5'h00, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'h00F000F0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("or",       5'h01, 32'h12340000, 32'h00005678, 0, 32'h12345678, 0, 0, 0, 0, 0));
        vecs.push_back(mk("xor",      5'h03, 32'hFFFF0000, 32'h0F0F0F0F, 0, 32'hF0F00F0F, 0, 0, 0, 0, 0));
        vecs.push_back(mk("nor",      5'h04, 32'h0F0F0000, 32'h00000F0F, 0, 32'hF0F0F0F0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sub",      5'h05, 32'h00000005, 32'h00000007, 0, 32'hFFFFFFFE, 0, 0, 0, 0, 0));
        vecs.push_back(mk("slt",      5'h06, 32'h80000000, 32'h00000001, 0, 32'h00000001, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sltu",     5'h07, 32'h80000000, 32'h00000001, 0, 32'h00000000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sll",      5'h08, 32'hFFFFFFFF, 32'h00000003, 4, 32'h00000030, 0, 0, 0, 0, 0));
        vecs.push_back(mk("srl",      5'h09, 32'hFFFFFFFF, 32'h80000000, 4, 32'h08000000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("sra",      5'h0A, 32'h12345678, 32'h80000000, 4, 32'hF8000000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lui",      5'h0B, 32'hFFFFFFFF, 32'h00001234, 0, 32'h12340000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("undef_1f", 5'h1F, 32'h11111111, 32'h22222222, 3, 32'h00000000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("mult_neg", 5'h11, 32'hFFFFFFFE, 32'h00000003, 0, 32'hFFFFFFFA, 32, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFA));
        vecs.push_back(mk("multu_max",5'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h00000001, 32, 0, 1, 32'hFFFFFFFE, 32'h00000001));
        vecs.push_back(mk("mult_7m3", 5'h11, 32'h00000007, 32'hFFFFFFFD, 0, 32'hFFFFFFEB, 32, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFEB));
        vecs.push_back(mk("div_m7_2", 5'h13, 32'hFFFFFFF9, 32'h00000002, 0, 32'hFFFFFFFD, 32, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFD));
        vecs.push_back(mk("div_7_m2", 5'h13, 32'h00000007, 32'hFFFFFFFE, 0, 32'hFFFFFFFD, 32, 0, 1, 32'h00000001, 32'hFFFFFFFD));
        vecs.push_back(mk("divu_z",   5'h12, 32'h00000007, 32'h00000000, 0, 32'hFFFFFFFF, 32, 1, 1, 32'h00000007, 32'hFFFFFFFF));
        vecs.push_back(mk("div_z_neg",5'h13, 32'hFFFFFFF9, 32'h00000000, 0, 32'hFFFFFFFF, 32, 1, 1, 32'hFFFFFFF9, 32'hFFFFFFFF));
        vecs.push_back(mk("div_ovf",  5'h13, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 32, 0, 1, 32'h00000000, 32'h80000000));
        vecs.push_back(mk("divu_100", 5'h12, 32'h00000064, 32'h00000007, 0, 32'h0000000E, 32, 0, 1, 32'h00000002, 32'h0000000E));
        vecs.push_back(mk("undef_0c", 5'h0C, 32'hAAAAAAAA, 32'h55555555, 0, 32'h00000000, 0, 0, 1, 32'h00000002, 32'h0000000E));

        foreach (vecs[i]) begin
            run_op(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].sh, res, z, dz, lat, bn, va, rh);
            check({vecs[i].name, "_res"},     res, vecs[i].exp_res);
            check({vecs[i].name, "_zero"},    z,   (vecs[i].exp_res == 32'h0));
            check({vecs[i].name, "_lat"},     64'(lat), 64'(vecs[i].exp_lat));
            check({vecs[i].name, "_busy"},    64'(bn),  64'(vecs[i].exp_lat));
            check({vecs[i].name, "_divzero"}, dz,  vecs[i].exp_dz);
            check({vecs[i].name, "_pulse"},   va,  0);
            check({vecs[i].name, "_hold"},    rh,  vecs[i].exp_res);
            if (vecs[i].has_hilo) begin
                read_reg(5'h14, hi);
                check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
                read_reg(5'h15, lo);
                check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
            end
        end

        // ---------------- ADD start ignored while MULTU busy ----------------
        @(negedge i_clk);
        i_ALUCtrl = 5'h10; i_A = 32'h00010000; i_B = 32'h00010000; i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0; i_A = $urandom; i_B = $urandom;
        vcnt = 0; vlat = -1; bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_valid) begin
                vcnt++;
                if (vlat < 0) vlat = k;
            end
            if (o_busy) bcnt++;
            if (k == 4) begin
                i_ALUCtrl = 5'h02; i_A = 32'h1; i_B = 32'h1; i_start = 1'b1;
            end else if (k == 5) begin
                i_start = 1'b0;
            end
            @(posedge i_clk);
            #1;
        end
        check("busy_ign_vcount", 64'(vcnt), 1);
        check("busy_ign_vlat",   64'(vlat), 32);
        check("busy_ign_bcount", 64'(bcnt), 32);
        check("busy_ign_result", o_result, 32'h00000000);
        read_reg(5'h14, hi);
        check("busy_ign_hi", hi, 32'h00000001);
        read_reg(5'h15, lo);
        check("busy_ign_lo", lo, 32'h00000000);

        // ---------------- i_start held high ----------------
        @(negedge i_clk);
        i_ALUCtrl = 5'h02; i_A = 32'h1; i_B = 32'h1; i_start = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) vcnt++;
        end
        i_start = 1'b0;
        check("held_start_pulses", 64'(vcnt), 4);
        check("held_start_result", o_result, 32'h00000002);
        repeat (2) @(posedge i_clk);

        // ---------------- reset in the middle of DIVU ----------------
        run_op(5'h02, 32'h1, 32'h2, 0, res, z, dz, lat, bn, va, rh);
        check("pre_rst_add", res, 32'h00000003);
        @(negedge i_clk);
        i_ALUCtrl = 5'h12; i_A = 32'h12345678; i_B = 32'h00000003; i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (10) @(posedge i_clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("midrst_busy",   o_busy,   0);
        check("midrst_valid",  o_valid,  0);
        check("midrst_result", o_result, 0);
        check("midrst_zero",   o_zero,   1);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge i_clk);
            #1;
            if (o_valid || o_busy) vcnt++;
        end
        check("midrst_no_activity", 64'(vcnt), 0);
        read_reg(5'h14, hi);
        check("midrst_hi", hi, 0);
        read_reg(5'h15, lo);
        check("midrst_lo", lo, 0);
        run_op(5'h06, 32'h80000000, 32'h00000001, 0, res, z, dz, lat, bn, va, rh);
        check("post_rst_slt", res, 32'h00000001);
        check("post_rst_slt_lat", 64'(lat), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
